// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Purpose:
//   Turns a simple command/response request interface into single APB
//   transfers. Each accepted command runs through SETUP and ACCESS on the APB
//   bus. The result is then held in RESP until the requester takes it. A
//   programmable wait-state timeout ends a transfer whose completer never
//   raises PREADY.
//
// Handshake semantics (both request-side channels):
//   A transfer on a channel happens on a rising PCLK edge where valid and
//   ready are both 1. The producer holds valid, and the payload that goes with
//   it, until that edge. The consumer may raise or drop ready in any cycle.
//   cmd_ready is high only in IDLE with PRESET low. rsp_valid is high only in
//   RESP, and the response fields do not change while it is high.
//
// Parameters:
//   TIMEOUT     - maximum number of ACCESS cycles spent waiting for PREADY
//                 (0 disables the timeout)
//
// Ports:
//   PCLK, PRESET        - clock, synchronous active-high reset
//   cmd_valid/ready     - command handshake
//   cmd_write           - 1 = write, 0 = read
//   cmd_addr, cmd_wdata - transfer address and write data
//   rsp_valid/ready     - response handshake
//   rsp_rdata           - read data (0 for writes and timeouts)
//   rsp_err             - completer error or timeout
//   rsp_timeout         - transfer ended by timeout
//   PSELx, PENABLE, PWRITE, PADDR, PWDATA - APB requester outputs
//   PRDATA, PREADY, PSLVERR               - APB completer returns
//   busy                - high whenever the FSM is not in IDLE
//   err_count           - saturating count of error responses
//   fsm_state           - current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,

    output logic        PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,

    output logic        busy,
    output logic [7:0]  err_count,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The wait counter never needs to go past TIMEOUT. The extra headroom
    // keeps the width legal when TIMEOUT is 0, which is the disabled case.
    localparam int unsigned      CW          = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0]    TIMEOUT_CNT = CW'(TIMEOUT);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;

    logic cmd_fire;
    logic rsp_fire;
    logic access_done;
    logic timeout_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        PSELx       = 1'b0;
        PENABLE     = 1'b0;
        cmd_fire    = 1'b0;
        rsp_fire    = 1'b0;
        access_done = 1'b0;
        timeout_hit = 1'b0;

        case (state)
            IDLE: begin
                // cmd_ready is gated by PRESET so that no command looks
                // accepted in a cycle that reset is about to discard.
                cmd_ready = !PRESET;
                if (cmd_valid && !PRESET) begin
                    cmd_fire   = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                PSELx      = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                // PREADY wins over a timeout that would fire in the same cycle.
                if (PREADY) begin
                    access_done = 1'b1;
                    state_next  = RESP;
                end else if ((TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT)) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Datapath: APB request registers, wait counter, response, error count
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            wait_cnt    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            // The request registers load only on acceptance. This holds
            // them stable from SETUP through the end of ACCESS, and they
            // keep their last value while the bus is idle.
            if (cmd_fire) begin
                PWRITE   <= cmd_write;
                PADDR    <= cmd_addr;
                PWDATA   <= cmd_wdata;
                wait_cnt <= '0;
            end else if ((state == ACCESS) && !PREADY && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // PRDATA and PSLVERR are sampled only on the completing cycle.
            if (access_done) begin
                rsp_rdata   <= PWRITE ? 32'd0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (timeout_hit) begin
                rsp_rdata   <= 32'd0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end

            if (rsp_fire && rsp_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//
// Directed bench for apb_master, instantiated with TIMEOUT = 4. The bench
// acts as the requester and the APB completer, one cycle at a time.
// Expected values are written by hand for each vector. The error counter is
// modelled with a saturating expected count.
// -----------------------------------------------------------------------------
module tb_apb_master;

    localparam int unsigned TO = 4;

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        busy;
    logic [7:0]  err_count;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ec   = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_master #(.TIMEOUT(TO)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .busy        (busy),
        .err_count   (err_count),
        .fsm_state   (fsm_state)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: wait for the rising edge, then move 1 time unit past it so
    // that checks and new input values are never on the edge itself.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Driver: a full transfer
    //   waits    - ACCESS cycles with PREADY=0 before PREADY=1
    //   hold     - cycles rsp_ready stays low while the response is shown
    //   exp_*    - hand-computed expected results
    // ------------------------------------------------------------------
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic slverr,
                        input int hold, input int exp_acc, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic exp_to);
        int n_acc;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        PREADY    = 1'b0;
        check("idle_cmd_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        cmd_write = ~wr;
        // SETUP
        check("setup_psel", PSELx, 1'b1);
        check("setup_penable", PENABLE, 1'b0);
        check("setup_paddr", PADDR, addr);
        check("setup_cmd_ready", cmd_ready, 1'b0);
        step();
        // ACCESS cycles, bounded
        n_acc = 0;
        while (PENABLE === 1'b1 && n_acc < 20) begin
            n_acc++;
            check("access_psel", PSELx, 1'b1);
            check("access_paddr", PADDR, addr);
            check("access_pwdata", PWDATA, wdata);
            check("access_pwrite", PWRITE, wr);
            if (n_acc > waits) begin
                PREADY  = 1'b1;
                PRDATA  = rdata;
                PSLVERR = slverr;
            end else begin
                // Junk that must be ignored while PREADY is low.
                PREADY  = 1'b0;
                PRDATA  = 32'hDEAD_0000 | n_acc;
                PSLVERR = 1'b1;
            end
            step();
        end
        PREADY  = 1'b0;
        PRDATA  = 32'h1357_9BDF;
        PSLVERR = 1'b1;
        check("access_cycles", n_acc, exp_acc);
        // RESP, optionally with backpressure and a new command being offered
        check("resp_state", fsm_state, 2'd3);
        check("resp_psel", PSELx, 1'b0);
        check("resp_penable", PENABLE, 1'b0);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_err", rsp_err, exp_err);
            check("hold_timeout", rsp_timeout, exp_to);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            step();
        end
        cmd_valid = 1'b0;
        check("resp_valid", rsp_valid, 1'b1);
        check("resp_rdata", rsp_rdata, exp_rdata);
        check("resp_err", rsp_err, exp_err);
        check("resp_timeout", rsp_timeout, exp_to);
        check("resp_busy", busy, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        if (exp_err && exp_ec < 255) exp_ec++;
        check("done_rsp_valid", rsp_valid, 1'b0);
        check("done_busy", busy, 1'b0);
        check("done_paddr_held", PADDR, addr);
        check("done_err_count", err_count, exp_ec);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state. A command is offered during reset and must be refused.
        step();
        cmd_valid = 1'b1;
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_psel", PSELx, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_err_count", err_count, 8'h0);
        check("rst_busy", busy, 1'b0);
        cmd_valid = 1'b0;
        PRESET    = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Write, no waits
        xfer(1'b1, 32'h8, 32'h1234, 0, 32'hFFFF_FFFF, 1'b0, 0, 1, 32'h0, 1'b0, 1'b0);
        // Read, 3 wait states
        xfer(1'b0, 32'h4, 32'h0, 3, 32'hA5A5_A5A5, 1'b0, 0, 4, 32'hA5A5_A5A5, 1'b0, 1'b0);
        // Completer error on a read: err_count 0 -> 1
        xfer(1'b0, 32'h10, 32'h0, 0, 32'h77, 1'b1, 0, 1, 32'h77, 1'b1, 1'b0);
        check("slverr_count_one", err_count, 8'd1);
        // Timeout: PREADY never comes, 5 ACCESS cycles
        xfer(1'b0, 32'hC, 32'h0, 99, 32'h0, 1'b0, 0, 5, 32'h0, 1'b1, 1'b1);
        // PREADY on the 5th ACCESS cycle: normal completion
        xfer(1'b0, 32'h14, 32'h0, 4, 32'h5A, 1'b0, 0, 5, 32'h5A, 1'b0, 1'b0);
        // Write with waits under 10 cycles of response backpressure
        xfer(1'b1, 32'h20, 32'hCAFE, 2, 32'hFFFF_0000, 1'b0, 10, 3, 32'h0, 1'b0, 1'b0);
        // Write that times out
        xfer(1'b1, 32'h24, 32'hBEEF, 99, 32'h0, 1'b0, 0, 5, 32'h0, 1'b1, 1'b1);
        check("err_count_three", err_count, 8'd3);

        // Reset in mid-ACCESS aborts the transfer
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h30;
        step();
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        step();
        step();
        check("pre_abort_penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        step();
        check("abort_psel", PSELx, 1'b0);
        check("abort_penable", PENABLE, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_err_count", err_count, 8'd0);
        check("abort_paddr", PADDR, 32'h0);
        check("abort_cmd_ready", cmd_ready, 1'b0);
        exp_ec = 0;
        PRESET = 1'b0;
        step();
        check("after_abort_rsp_valid", rsp_valid, 1'b0);
        check("after_abort_cmd_ready", cmd_ready, 1'b1);

        // Saturation: 260 error responses
        for (int i = 0; i < 260; i++) begin
            xfer(1'b0, 32'h100 + i, 32'h0, 0, 32'h0, 1'b1, 0, 1, 32'h0, 1'b1, 1'b0);
        end
        check("err_count_saturated", err_count, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of ACCESS cycles spent waiting for PREADY; 0 disables the timeout.
REQ-002 PCLK  input  1  single clock; all logic samples on the rising edge.
REQ-003 PRESET  input  1  reset, synchronous and active-high.
REQ-004 cmd_valid  input  1  the requester offers a transfer.
REQ-005 cmd_ready  output  1  the master accepts the offered transfer.
REQ-006 cmd_write  input  1  1 selects a write transfer, 0 selects a read.
REQ-007 cmd_addr  input  32  transfer address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  a completed-transfer response is available.
REQ-010 rsp_ready  input  1  the requester consumes the response.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and for timed-out transfers.
REQ-012 rsp_err  output  1  the transfer ended with PSLVERR=1 or a timeout.
REQ-013 rsp_timeout  output  1  the transfer ended by timeout.
REQ-014 PSELx, PENABLE, PWRITE  output  1 each  APB control signals.
REQ-015 PADDR, PWDATA  output  32 each  APB address and write data.
REQ-016 PRDATA  input  32; PREADY, PSLVERR  input  1 each  APB completer return signals.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err_count  output  8  saturating count of responses with rsp_err=1.

Function
REQ-019 The state machine SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-020 cmd_ready SHALL equal 1 only in IDLE; a handshake (cmd_valid & cmd_ready) SHALL register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, and move the state to SETUP.
REQ-021 SETUP SHALL last exactly one cycle with PSELx=1 and PENABLE=0, then move to ACCESS.
REQ-022 In ACCESS, PSELx and PENABLE SHALL both be 1; the state SHALL stay in ACCESS until PREADY=1 is sampled.
REQ-023 PADDR, PWDATA and PWRITE SHALL stay constant from SETUP through the last ACCESS cycle, and SHALL hold their last values in IDLE and RESP.
REQ-024 In IDLE and RESP, PSELx and PENABLE SHALL both be 0.
REQ-025 On the ACCESS cycle where PREADY=1:
- rsp_rdata = PRDATA for a read, 0 for a write;
- rsp_err = PSLVERR;
- rsp_timeout = 0;
- the state moves to RESP.
REQ-026 Each ACCESS cycle with PREADY=0 SHALL increment a wait counter (cleared on entry to SETUP).
REQ-027 When TIMEOUT != 0 and the wait counter reaches TIMEOUT with PREADY still 0, the transfer SHALL end on that edge: rsp_err=1, rsp_timeout=1, rsp_rdata=0, state moves to RESP.
REQ-028 If PREADY=1 arrives on the same cycle the timeout would fire, the transfer SHALL complete normally per REQ-025, with no timeout.
REQ-029 An ACCESS phase SHALL therefore last at most TIMEOUT+1 cycles.
REQ-030 In RESP, rsp_valid SHALL be 1; rsp_rdata, rsp_err and rsp_timeout SHALL stay stable until rsp_valid & rsp_ready, after which the state returns to IDLE.
REQ-031 A new command SHALL NOT be accepted before IDLE is reached; the minimum transfer period is 4 cycles (IDLE, SETUP, ACCESS, RESP).
REQ-032 err_count SHALL increment by 1 on each response handshake where rsp_err=1, and SHALL saturate at 255.
REQ-033 PSLVERR and PRDATA SHALL be ignored in every cycle except the completing ACCESS cycle.

Reset
REQ-034 While PRESET=1 at a rising edge, the following SHALL be forced on that edge:
- state = IDLE;
- PSELx = PENABLE = PWRITE = 0;
- PADDR = PWDATA = 0;
- rsp_valid = rsp_err = rsp_timeout = 0, rsp_rdata = 0;
- err_count = 0, wait counter = 0.
REQ-035 cmd_ready SHALL be 0 during any cycle where PRESET=1.
REQ-036 A reset asserted during SETUP, ACCESS or RESP SHALL abort the transfer with no response issued; the bus SHALL be idle on the following cycle.

Verification
REQ-037 Write, no waits: cmd write addr 0x8 data 0x1234, completer PREADY=1 immediately -> SETUP then one ACCESS cycle with PADDR=0x8, PWDATA=0x1234; rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-038 Read, 3 wait states: cmd read addr 0x4, PREADY low for 3 ACCESS cycles, PRDATA=0xA5A5A5A5 on the 4th -> 4 ACCESS cycles; rsp_rdata=0xA5A5A5A5; PADDR stable throughout.
REQ-039 Slave error: read with PSLVERR=1 and PREADY=1 -> rsp_err=1, rsp_timeout=0, err_count goes 0->1.
REQ-040 Timeout: TIMEOUT=4, PREADY held 0 -> exactly 5 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PREADY on the 5th ACCESS cycle instead -> normal completion.
REQ-041 Backpressure and reset: rsp_ready=0 for 10 cycles -> rsp_valid and response fields held, cmd_ready=0; PRESET=1 in mid-ACCESS -> next cycle PSELx=0, rsp_valid=0, err_count=0.
REQ-042 Saturation: 260 consecutive error responses -> err_count=255.
